hazard_fwd_unit: RTL and testbench
==================================

// Module: hazard_fwd_unit
// PURPOSE
//  Parametrised hazard, forwarding and flush controller for the MIPS150 pipeline; successor to the fixed one-deep forwarding in decode control.
//  Tracks in-flight destination registers over DEPTH stages in a registered scoreboard.
//  Drives per-operand forwarding selects, load-use stalls and a branch/jump flush sequence.
//  Sits between decode (ID) and the datapath operand muxes.
// PARAMETERS
//  RADDR       5  register address width (32-entry file)
//  DEPTH       3  tracked stages after ID (1=EX .. DEPTH=oldest)
//  LOAD_LAT    1  a load result is forwardable only from stage index >= 1+LOAD_LAT
//  FLUSH_SLOTS 1  cycles flush is held after a redirect (1..7)
// PORTS
//  clk          in   1      clock, all state on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  id_valid     in   1      ID holds a real instruction
//  id_rs        in   RADDR  source A register
//  id_rt        in   RADDR  source B register
//  id_uses_rs   in   1      instruction reads rs
//  id_uses_rt   in   1      instruction reads rt
//  id_wr_en     in   1      instruction writes a register
//  id_wr_addr   in   RADDR  destination (rd, rt or 31, already muxed)
//  id_is_load   in   1      instruction is LB/LH/LW/LBU/LHU
//  redirect     in   1      taken branch/jump resolved this cycle
//  issue        out  1      ID instruction enters stage 1 this cycle
//  stall        out  1      hold PC and IF/ID, insert bubble in stage 1
//  flush        out  1      squash IF/ID contents
//  fwd_a_sel    out  FW     0 = register file, k = stage k result; FW = $clog2(DEPTH+1)
//  fwd_b_sel    out  FW     as fwd_a_sel, for rt
// BEHAVIOUR
//  Reset: all scoreboard entries invalid; FSM=RUN; issue, stall, flush, fwd_*_sel = 0. Reset mid-stall or mid-flush aborts immediately.
//  Scoreboard entry k = {vld, waddr, is_load}. On posedge: entry[k] <= entry[k-1] for k>1; entry[1] <= issue ? ID fields : bubble.
//  Entry vld is set only if id_wr_en && id_wr_addr != 0; writes to $0 are never tracked.
//  Match per operand: the lowest k with vld && waddr == src && uses_src. No match -> sel 0. Youngest wins when several stages match.
//  Load-use: if the winning match is a load with k < 1+LOAD_LAT, then stall=1 and that operand's sel=0.
//  stall, fwd_*_sel and issue are combinational from ID inputs and registered state (0-cycle latency); they are 0 when !id_valid.
//  issue = id_valid & !stall & !redirect & (state==RUN).
//  FSM RUN: redirect -> FLUSH with cnt=FLUSH_SLOTS-1; flush=1 in the same cycle (combinational) and in every FLUSH cycle.
//  FSM FLUSH: cnt==0 -> RUN, else cnt--. A redirect during FLUSH reloads cnt (restart). stall is forced 0 while flushing.
//  Redirect and load-use in the same cycle: redirect wins; stall=0 and stage 1 gets a bubble.
//  A stall lasts until the load reaches stage 1+LOAD_LAT, i.e. LOAD_LAT cycles for an adjacent load. Bubbles keep advancing during the stall.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
//   - Each counter increments on every cycle its signal is 1, saturates at 32'hFFFFFFFF and is cleared by reset.
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  hazard_pkg.vh: FWD_RF=0 constant, FSM state encodings (RUN=0, FLUSH=1), entry field widths.
//  Sub-module hazard_scoreboard: DEPTH-entry shift register plus per-operand priority match (outputs hit index and hit_is_load).
//  Top level: load-use compare, issue logic, flush FSM and the optional counters.
// TESTING (DEPTH=3, LOAD_LAT=1, FLUSH_SLOTS=1)
//  1. addu $3,$1,$2 then addu $4,$3,$3 -> fwd_a_sel=1, fwd_b_sel=1, stall=0, issue=1.
//  2. lw $5,0($1) then addu $6,$5,$0 -> stall=1 for 1 cycle, then fwd_a_sel=2, fwd_b_sel=0, issue=1.
//  3. addu $0,$1,$2 then addu $4,$0,$0 -> fwd_a_sel=0, fwd_b_sel=0, no stall.
//  4. $7 written in stages 1 and 3, ID reads $7 -> fwd_a_sel=1. ID reads $7 with only stage 3 valid -> fwd_a_sel=3.
//  5. redirect=1 during load-use stall -> flush=1, stall=0, issue=0, stage 1 bubble; flush=0 after 1 cycle. Back-to-back redirect -> flush held.
//  6. rst_n low mid-stall and mid-flush -> all outputs 0 at once; after release, first ID instruction gets fwd 0.
//     With HAZ_PERF_CNT_EN: after test 2, stall_cnt=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard / forwarding controller:
// forwarding-select encoding, flush FSM states, scoreboard entry field
// widths and the saturating-counter helper used by the optional
// performance counters.
package hazard_pkg;

    // Forwarding select value meaning "take the operand from the register file"
    localparam int FWD_RF = 0;

    // Scoreboard entry field widths (address width is a module parameter)
    localparam int ENTRY_VLD_W  = 1;
    localparam int ENTRY_LOAD_W = 1;

    // Flush slot counter width; FLUSH_SLOTS is limited to 1..7
    localparam int FLUSH_CNT_W = 3;

    // Flush sequencing states
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fsm_state_e;

    // 32-bit counter step that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] cur, input logic en);
        logic [31:0] res;
        if (en && (cur != 32'hFFFF_FFFF)) begin
            res = cur + 32'd1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: a DEPTH-entry shift register of
// {vld, waddr, is_load} fed from ID, plus a per-operand priority match
// that reports the youngest stage holding the requested register.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int RADDR = 5,
    parameter  int DEPTH = 3,
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_vld,
    input  logic [RADDR-1:0] shift_waddr,
    input  logic             shift_is_load,
    input  logic [RADDR-1:0] rs,
    input  logic [RADDR-1:0] rt,
    input  logic             uses_rs,
    input  logic             uses_rt,
    output logic [FW-1:0]    hit_a,
    output logic             hit_a_is_load,
    output logic [FW-1:0]    hit_b,
    output logic             hit_b_is_load
);

    logic             vld_r   [1:DEPTH];
    logic [RADDR-1:0] waddr_r [1:DEPTH];
    logic             load_r  [1:DEPTH];

    logic [FW-1:0]    hit_a_s;
    logic             hit_a_ld_s;
    logic [FW-1:0]    hit_b_s;
    logic             hit_b_ld_s;

    // Advance every entry one stage; stage 1 takes the ID fields or a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                vld_r[k]   <= 1'b0;
                waddr_r[k] <= '0;
                load_r[k]  <= 1'b0;
            end
        end else begin
            vld_r[1]   <= shift_vld;
            waddr_r[1] <= shift_waddr;
            load_r[1]  <= shift_is_load;
            for (int k = 2; k <= DEPTH; k++) begin
                vld_r[k]   <= vld_r[k-1];
                waddr_r[k] <= waddr_r[k-1];
                load_r[k]  <= load_r[k-1];
            end
        end
    end

    // Priority match: scan oldest to youngest so the lowest stage index wins
    always_comb begin
        hit_a_s    = FW'(FWD_RF);
        hit_a_ld_s = 1'b0;
        hit_b_s    = FW'(FWD_RF);
        hit_b_ld_s = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (uses_rs && vld_r[k] && (waddr_r[k] == rs)) begin
                hit_a_s    = FW'(k);
                hit_a_ld_s = load_r[k];
            end else begin
                hit_a_s    = hit_a_s;
                hit_a_ld_s = hit_a_ld_s;
            end
            if (uses_rt && vld_r[k] && (waddr_r[k] == rt)) begin
                hit_b_s    = FW'(k);
                hit_b_ld_s = load_r[k];
            end else begin
                hit_b_s    = hit_b_s;
                hit_b_ld_s = hit_b_ld_s;
            end
        end
    end

    assign hit_a         = hit_a_s;
    assign hit_a_is_load = hit_a_ld_s;
    assign hit_b         = hit_b_s;
    assign hit_b_is_load = hit_b_ld_s;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard, forwarding and flush controller for the MIPS150 pipeline.
// Sits between ID and the datapath operand muxes: picks forwarding
// sources, raises load-use stalls and sequences the branch/jump flush.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall_cnt and
// flush_cnt outputs; without it those ports do not exist.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter  int RADDR       = 5,
    parameter  int DEPTH       = 3,
    parameter  int LOAD_LAT    = 1,
    parameter  int FLUSH_SLOTS = 1,
    localparam int FW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_wr_en,
    input  logic [RADDR-1:0] id_wr_addr,
    input  logic             id_is_load,
    input  logic             redirect,
    output logic             issue,
    output logic             stall,
    output logic             flush,
    output logic [FW-1:0]    fwd_a_sel,
    output logic [FW-1:0]    fwd_b_sel
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    // A load result is usable only from this stage index upward
    localparam logic [FW:0]            LU_LIMIT   = (FW + 1)'(1 + LOAD_LAT);
    localparam logic [FLUSH_CNT_W-1:0] CNT_RELOAD = FLUSH_CNT_W'(FLUSH_SLOTS - 1);

    fsm_state_e             state_r;
    fsm_state_e             state_nxt_s;
    logic [FLUSH_CNT_W-1:0] cnt_r;
    logic [FLUSH_CNT_W-1:0] cnt_nxt_s;

    logic [FW-1:0] hit_a_s;
    logic          hit_a_ld_s;
    logic [FW-1:0] hit_b_s;
    logic          hit_b_ld_s;

    logic          lu_a_s;
    logic          lu_b_s;
    logic          flushing_s;
    logic          stall_s;
    logic          issue_s;
    logic [FW-1:0] fwd_a_s;
    logic [FW-1:0] fwd_b_s;

    logic             shift_vld_s;
    logic [RADDR-1:0] shift_waddr_s;
    logic             shift_is_load_s;

    // Only issued instructions that really write a non-zero register are tracked
    assign shift_vld_s     = issue_s && id_wr_en && (id_wr_addr != '0);
    assign shift_waddr_s   = issue_s ? id_wr_addr : '0;
    assign shift_is_load_s = issue_s && id_is_load;

    hazard_scoreboard #(
        .RADDR (RADDR),
        .DEPTH (DEPTH)
    ) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .shift_vld     (shift_vld_s),
        .shift_waddr   (shift_waddr_s),
        .shift_is_load (shift_is_load_s),
        .rs            (id_rs),
        .rt            (id_rt),
        .uses_rs       (id_uses_rs),
        .uses_rt       (id_uses_rt),
        .hit_a         (hit_a_s),
        .hit_a_is_load (hit_a_ld_s),
        .hit_b         (hit_b_s),
        .hit_b_is_load (hit_b_ld_s)
    );

    // Hazard decode: load-use detection, stall, issue and forwarding selects
    always_comb begin
        lu_a_s     = hit_a_ld_s && ({1'b0, hit_a_s} < LU_LIMIT);
        lu_b_s     = hit_b_ld_s && ({1'b0, hit_b_s} < LU_LIMIT);
        flushing_s = redirect || (state_r == ST_FLUSH);
        stall_s    = id_valid && (lu_a_s || lu_b_s) && !flushing_s;
        issue_s    = id_valid && !stall_s && !redirect && (state_r == ST_RUN);
        if (id_valid && !lu_a_s) begin
            fwd_a_s = hit_a_s;
        end else begin
            fwd_a_s = FW'(FWD_RF);
        end
        if (id_valid && !lu_b_s) begin
            fwd_b_s = hit_b_s;
        end else begin
            fwd_b_s = FW'(FWD_RF);
        end
    end

    // Flush FSM state and slot counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Flush FSM next state: a redirect always (re)starts the slot count
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (redirect) begin
                    state_nxt_s = ST_FLUSH;
                    cnt_nxt_s   = CNT_RELOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (redirect) begin
                    cnt_nxt_s = CNT_RELOAD;
                end else if (cnt_r == '0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s = cnt_r - FLUSH_CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Reset forces every control output low immediately, even mid-sequence
    assign issue     = rst_n && issue_s;
    assign stall     = rst_n && stall_s;
    assign flush     = rst_n && flushing_s;
    assign fwd_a_sel = rst_n ? fwd_a_s : FW'(FWD_RF);
    assign fwd_b_sel = rst_n ? fwd_b_s : FW'(FWD_RF);

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating count of stall and flush cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r <= sat_inc32(stall_cnt_r, stall);
            flush_cnt_r <= sat_inc32(flush_cnt_r, flush);
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit (DEPTH=3, LOAD_LAT=1,
// FLUSH_SLOTS=1): a cycle-by-cycle vector table plus hand-written
// asynchronous-reset sequences. Expected outputs go into a queue when a
// cycle is driven and are popped and compared on the falling edge.
module tb_hazard_fwd_unit;

    typedef struct packed {
        logic       issue;
        logic       stall;
        logic       flush;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    typedef struct {
        string      nm;
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       wen;
        logic [4:0] wa;
        logic       ld;
        logic       rdr;
        exp_t       e;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_wr_en;
    logic [4:0] id_wr_addr;
    logic       id_is_load;
    logic       redirect;
    logic       issue;
    logic       stall;
    logic       flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int   pass_cnt;
    int   total_cnt;
    exp_t exp_q[$];
    vec_t tbl[22];

    hazard_fwd_unit #(
        .RADDR       (5),
        .DEPTH       (3),
        .LOAD_LAT    (1),
        .FLUSH_SLOTS (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .id_wr_en   (id_wr_en),
        .id_wr_addr (id_wr_addr),
        .id_is_load (id_is_load),
        .redirect   (redirect),
        .issue      (issue),
        .stall      (stall),
        .flush      (flush),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input string nm, input logic v, input logic [4:0] rs,
                                input logic [4:0] rt, input logic urs, input logic urt,
                                input logic wen, input logic [4:0] wa, input logic ld,
                                input logic rdr, input logic ei, input logic es,
                                input logic ef, input logic [1:0] fa, input logic [1:0] fb);
        vec_t r;
        r.nm = nm; r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
        r.wen = wen; r.wa = wa; r.ld = ld; r.rdr = rdr;
        r.e = '{issue: ei, stall: es, flush: ef, fa: fa, fb: fb};
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_outputs(input string nm, input exp_t e);
        check({nm, ".issue"}, {31'd0, issue}, {31'd0, e.issue});
        check({nm, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
        check({nm, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
        check({nm, ".fwd_a"}, {30'd0, fwd_a_sel}, {30'd0, e.fa});
        check({nm, ".fwd_b"}, {30'd0, fwd_b_sel}, {30'd0, e.fb});
    endtask

    task automatic drive(input vec_t v);
        id_valid   = v.v;
        id_rs      = v.rs;
        id_rt      = v.rt;
        id_uses_rs = v.urs;
        id_uses_rt = v.urt;
        id_wr_en   = v.wen;
        id_wr_addr = v.wa;
        id_is_load = v.ld;
        redirect   = v.rdr;
    endtask

    // One full cycle: drive, queue the expectation, compare on the falling edge
    task automatic apply(input vec_t v);
        exp_t e;
        drive(v);
        exp_q.push_back(v.e);
        @(negedge clk);
        e = exp_q.pop_front();
        cmp_outputs(v.nm, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        vec_t tmp;
        pass_cnt  = 0;
        total_cnt = 0;

        //         name        v  rs  rt  urs urt wen wa  ld rdr | iss stl fl fa fb
        tbl[0]  = mk("idle",    0, 0,  0,  0,  0,  0,  0,  0, 0,    0,  0,  0, 0, 0);
        tbl[1]  = mk("t1_prod", 1, 1,  2,  1,  1,  1,  3,  0, 0,    1,  0,  0, 0, 0);
        tbl[2]  = mk("t1_cons", 1, 3,  3,  1,  1,  1,  4,  0, 0,    1,  0,  0, 1, 1);
        tbl[3]  = mk("t2_lw",   1, 1,  5,  1,  0,  1,  5,  1, 0,    1,  0,  0, 0, 0);
        tbl[4]  = mk("t2_stall",1, 5,  0,  1,  1,  1,  6,  0, 0,    0,  1,  0, 0, 0);
        tbl[5]  = mk("t2_fwd",  1, 5,  0,  1,  1,  1,  6,  0, 0,    1,  0,  0, 2, 0);
        tbl[6]  = mk("t3_w0",   1, 1,  2,  1,  1,  1,  0,  0, 0,    1,  0,  0, 0, 0);
        tbl[7]  = mk("t3_r0",   1, 0,  0,  1,  1,  1,  4,  0, 0,    1,  0,  0, 0, 0);
        tbl[8]  = mk("t4_w7a",  1, 0,  0,  0,  0,  1,  7,  0, 0,    1,  0,  0, 0, 0);
        tbl[9]  = mk("t4_w8",   1, 0,  0,  0,  0,  1,  8,  0, 0,    1,  0,  0, 0, 0);
        tbl[10] = mk("t4_w7b",  1, 0,  0,  0,  0,  1,  7,  0, 0,    1,  0,  0, 0, 0);
        tbl[11] = mk("t4_young",1, 7,  8,  1,  1,  0,  0,  0, 0,    1,  0,  0, 1, 2);
        tbl[12] = mk("t4_urs0", 1, 7,  7,  0,  1,  0,  0,  0, 0,    1,  0,  0, 0, 2);
        tbl[13] = mk("t4_old",  1, 7,  0,  1,  0,  0,  0,  0, 0,    1,  0,  0, 3, 0);
        tbl[14] = mk("t5_lw",   1, 1,  0,  1,  0,  1,  9,  1, 0,    1,  0,  0, 0, 0);
        tbl[15] = mk("t5_rdr",  1, 9,  0,  1,  0,  1, 10,  0, 1,    0,  0,  1, 0, 0);
        tbl[16] = mk("t5_fl",   1, 9,  0,  1,  0,  1, 10,  0, 0,    0,  0,  1, 2, 0);
        tbl[17] = mk("t5_run",  1, 1,  0,  1,  0,  1, 11,  0, 0,    1,  0,  0, 0, 0);
        tbl[18] = mk("t5_rdr1", 0, 0,  0,  0,  0,  0,  0,  0, 1,    0,  0,  1, 0, 0);
        tbl[19] = mk("t5_rdr2", 0, 0,  0,  0,  0,  0,  0,  0, 1,    0,  0,  1, 0, 0);
        tbl[20] = mk("t5_hold", 0, 0,  0,  0,  0,  0,  0,  0, 0,    0,  0,  1, 0, 0);
        tbl[21] = mk("t5_done", 0, 0,  0,  0,  0,  0,  0,  0, 0,    0,  0,  0, 0, 0);

        idle = tbl[0];

        // Reset state: outputs low even with a redirect and a valid instruction present
        rst_n = 1'b0;
        tmp = mk("rst", 1, 1, 2, 1, 1, 1, 3, 0, 1, 0, 0, 0, 0, 0);
        drive(tmp);
        #3;
        cmp_outputs("reset", tmp.e);
        drive(idle);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i]);
        end

`ifdef HAZ_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 32'd1);
        check("flush_cnt", flush_cnt, 32'd5);
`endif

        // Reset in the middle of a load-use stall
        apply(mk("t6_lw", 1, 1, 0, 1, 0, 1, 12, 1, 0, 1, 0, 0, 0, 0));
        tmp = mk("t6_haz", 1, 12, 12, 1, 1, 1, 13, 0, 0, 0, 1, 0, 0, 0);
        drive(tmp);
        #1;
        check("t6_pre_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        cmp_outputs("t6_rst_stall", '{issue: 1'b0, stall: 1'b0, flush: 1'b0, fa: 2'd0, fb: 2'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply(mk("t6_after", 1, 12, 12, 1, 1, 1, 13, 0, 0, 1, 0, 0, 0, 0));

        // Reset in the middle of a flush
        apply(mk("t6_rdr", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        drive(idle);
        #1;
        check("t6_pre_flush", {31'd0, flush}, 32'd1);
        rst_n = 1'b0;
        #1;
        cmp_outputs("t6_rst_flush", '{issue: 1'b0, stall: 1'b0, flush: 1'b0, fa: 2'd0, fb: 2'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply(mk("t6_run", 1, 13, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
`ifdef HAZ_PERF_CNT_EN
        check("stall_cnt_rst", stall_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
